// File: rtl/tl_ram_slave_if.sv
// tl_ram_slave_if: TileLink-UL channel A/D bundle between one master and one
// slave. SW sets the width of the a_source/d_source transaction tag.
interface tl_ram_slave_if #(
  parameter int SW = 4
) ();
  // Channel A: request, master to slave
  logic          a_valid;
  logic          a_ready;
  logic [2:0]    a_opcode;
  logic [2:0]    a_size;
  logic [SW-1:0] a_source;
  logic [63:0]   a_address;
  logic [7:0]    a_mask;
  logic [63:0]   a_data;
  // Channel D: response, slave to master
  logic          d_valid;
  logic          d_ready;
  logic [2:0]    d_opcode;
  logic [2:0]    d_size;
  logic [SW-1:0] d_source;
  logic          d_denied;
  logic [63:0]   d_data;

  modport slave (
    input  a_valid, a_opcode, a_size, a_source, a_address, a_mask, a_data,
    output a_ready,
    output d_valid, d_opcode, d_size, d_source, d_denied, d_data,
    input  d_ready
  );

  modport master (
    output a_valid, a_opcode, a_size, a_source, a_address, a_mask, a_data,
    input  a_ready,
    input  d_valid, d_opcode, d_size, d_source, d_denied, d_data,
    output d_ready
  );
endinterface

// File: rtl/tl_ram_slave.sv
// tl_ram_slave: TileLink-UL responder in front of a single-port 64-bit RAM.
// It takes one channel-A request at a time, does the RAM access in a single
// ACCESS cycle and holds the channel-D response in RESP until d_ready.
// Illegal, misaligned or out-of-range requests are answered with d_denied=1.
// Optional feature macro: TL_RAM_FASTPATH_EN -- when defined, a new request
// may be accepted in the same cycle the current response is handshaken.
module tl_ram_slave #(
  parameter logic [63:0] BASE_ADDR = 64'h0000_0000_8000_0000,
  parameter int          DEPTH     = 4096,
  parameter int          AW        = 12,
  parameter int          SW        = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  tl_ram_slave_if.slave       bus,
  output logic                busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [63:0] RAM_BYTES = 64'(DEPTH) * 64'd8;

  state_t        state_r, state_s;

  // Latched request
  logic [2:0]    op_r;
  logic [2:0]    size_r;
  logic [SW-1:0] src_r;
  logic [63:0]   addr_r;
  logic [7:0]    mask_r;
  logic [63:0]   wdata_r;

  // Registered response
  logic          busy_r;
  logic          d_valid_r;
  logic [2:0]    d_opcode_r;
  logic [2:0]    d_size_r;
  logic [SW-1:0] d_source_r;
  logic          d_denied_r;
  logic          d_rd_r;       // response carries RAM read data
  logic [63:0]   rd_word_r;

  // RAM array (never reset)
  logic [63:0]   mem_r [DEPTH];

  // Decode of the latched request
  logic [63:0]   offset_s;
  logic [AW-1:0] idx_s;
  logic          is_get_s;
  logic          is_put_s;
  logic          denied_s;

  // FSM strobes
  logic          accept_s;
  logic          load_d_s;
  logic          wr_en_s;
  logic          rd_en_s;

  // True when the address is not a multiple of the 2^size transfer width.
  function automatic logic misaligned(input logic [63:0] addr, input logic [2:0] size);
    logic mis;
    case (size)
      3'd0:    mis = 1'b0;
      3'd1:    mis = addr[0];
      3'd2:    mis = |addr[1:0];
      3'd3:    mis = |addr[2:0];
      default: mis = 1'b0;   // oversize is denied separately
    endcase
    return mis;
  endfunction

  // Request decode: offset from the RAM base, word index and deny conditions.
  // Addresses below BASE_ADDR wrap to a huge offset and are denied as out of range.
  always_comb begin
    offset_s = addr_r - BASE_ADDR;
    idx_s    = offset_s[AW+2:3];
    is_get_s = (op_r == 3'd4);
    is_put_s = (op_r == 3'd0) || (op_r == 3'd1);
    denied_s = (offset_s >= RAM_BYTES) ||
               (size_r > 3'd3) ||
               misaligned(addr_r, size_r) ||
               !(is_get_s || is_put_s);
  end

  // Next-state and per-cycle strobes for the IDLE/ACCESS/RESP sequence.
  always_comb begin
    state_s  = state_r;
    accept_s = 1'b0;
    load_d_s = 1'b0;
    wr_en_s  = 1'b0;
    rd_en_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.a_valid) begin
          accept_s = 1'b1;
          state_s  = ACCESS;
        end else begin
          state_s  = IDLE;
        end
      end
      ACCESS: begin
        load_d_s = 1'b1;
        wr_en_s  = is_put_s && !denied_s;
        rd_en_s  = is_get_s && !denied_s;
        state_s  = RESP;
      end
      RESP: begin
        if (bus.d_ready) begin
`ifdef TL_RAM_FASTPATH_EN
          if (bus.a_valid) begin
            accept_s = 1'b1;
            state_s  = ACCESS;
          end else begin
            state_s  = IDLE;
          end
`else
          state_s = IDLE;
`endif
        end else begin
          state_s = RESP;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State register, request latch and registered D-channel fields.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      busy_r     <= 1'b0;
      d_valid_r  <= 1'b0;
      d_opcode_r <= 3'd0;
      d_size_r   <= 3'd0;
      d_source_r <= '0;
      d_denied_r <= 1'b0;
      d_rd_r     <= 1'b0;
      op_r       <= 3'd0;
      size_r     <= 3'd0;
      src_r      <= '0;
      addr_r     <= 64'd0;
      mask_r     <= 8'd0;
      wdata_r    <= 64'd0;
    end else begin
      state_r   <= state_s;
      busy_r    <= (state_s != IDLE);
      d_valid_r <= (state_s == RESP);
      if (accept_s) begin
        op_r    <= bus.a_opcode;
        size_r  <= bus.a_size;
        src_r   <= bus.a_source;
        addr_r  <= bus.a_address;
        mask_r  <= bus.a_mask;
        wdata_r <= bus.a_data;
      end
      if (load_d_s) begin
        d_opcode_r <= is_get_s ? 3'd1 : 3'd0;
        d_size_r   <= size_r;
        d_source_r <= src_r;
        d_denied_r <= denied_s;
        d_rd_r     <= rd_en_s;
      end
    end
  end

  // Single-port RAM: byte-enabled write and synchronous read in ACCESS.
  // A write is suppressed in a reset cycle so reset never half-commits it.
  always_ff @(posedge clk) begin
    if (wr_en_s && rst_n) begin
      for (int b = 0; b < 8; b++) begin
        if (mask_r[b]) begin
          mem_r[idx_s][b*8 +: 8] <= wdata_r[b*8 +: 8];
        end
      end
    end
    if (rd_en_s) begin
      rd_word_r <= mem_r[idx_s];
    end
  end

`ifdef TL_RAM_FASTPATH_EN
  // Ready in IDLE, or in RESP when the current response leaves this cycle.
  assign bus.a_ready = (state_r == IDLE) || ((state_r == RESP) && bus.d_ready);
`else
  logic a_ready_r;

  // Ready is a registered copy of "next state is IDLE".
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_ready_r <= 1'b1;
    end else begin
      a_ready_r <= (state_s == IDLE);
    end
  end

  assign bus.a_ready = a_ready_r;
`endif

  assign bus.d_valid  = d_valid_r;
  assign bus.d_opcode = d_opcode_r;
  assign bus.d_size   = d_size_r;
  assign bus.d_source = d_source_r;
  assign bus.d_denied = d_denied_r;
  assign bus.d_data   = d_rd_r ? rd_word_r : 64'd0;
  assign busy         = busy_r;

endmodule

// File: tb/tb_tl_ram_slave.sv
// tb_tl_ram_slave: directed test of tl_ram_slave with a transaction-level
// reference model (outstanding request + word-addressed memory) checked on
// every cycle, plus literal expectations for the listed scenarios.
module tb_tl_ram_slave;

  localparam logic [63:0] BASE = 64'h0000_0000_8000_0000;
`ifdef TL_RAM_FASTPATH_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic clk;
  logic rst_n;
  logic busy;

  tl_ram_slave_if #(.SW(4)) bus ();

  tl_ram_slave dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [63:0] mem_m [longint];
  bit          m_seen, m_inflight, m_clean;
  int          m_age;
  logic [2:0]  m_op, m_size;
  logic [3:0]  m_src;
  logic        m_den;
  logic [63:0] m_data;
  bit          m_hs, m_rdy;

  // Response rules: deny on range/size/alignment/opcode, apply Put bytes.
  task automatic model_resp(input logic [2:0] op, input logic [2:0] size,
                            input logic [63:0] addr, input logic [7:0] mask,
                            input logic [63:0] data);
    logic [63:0] off;
    longint      idx;
    logic [63:0] w;
    off   = addr - BASE;
    idx   = longint'(off / 64'd8);
    m_den = (off >= 64'd32768) || (size > 3'd3) ||
            ((size <= 3'd3) && ((addr % (64'd1 << size)) != 64'd0)) ||
            !((op == 3'd0) || (op == 3'd1) || (op == 3'd4));
    m_op  = (op == 3'd4) ? 3'd1 : 3'd0;
    m_data = 64'd0;
    if (!m_den) begin
      if (op == 3'd4) begin
        m_data = mem_m.exists(idx) ? mem_m[idx] : 64'd0;
      end else begin
        w = mem_m.exists(idx) ? mem_m[idx] : 64'd0;
        for (int b = 0; b < 8; b++)
          if (mask[b]) w[b*8 +: 8] = data[b*8 +: 8];
        mem_m[idx] = w;
      end
    end
  endtask

  // Outstanding-request tracker: response visible from the 2nd cycle after acceptance.
  always @(posedge clk) begin
    if (!rst_n) begin
      m_seen = 1'b1; m_inflight = 1'b0; m_age = 0; m_clean = 1'b1;
    end else begin
      m_hs  = m_inflight && (m_age >= 1) && bus.d_ready;
      m_rdy = !m_inflight || (FAST && m_hs);
      if (m_hs) m_inflight = 1'b0;
      else if (m_inflight && m_age < 1) m_age = m_age + 1;
      if (bus.a_valid && m_rdy) begin
        m_inflight = 1'b1; m_age = 0; m_clean = 1'b0;
        m_size = bus.a_size; m_src = bus.a_source;
        model_resp(bus.a_opcode, bus.a_size, bus.a_address, bus.a_mask, bus.a_data);
      end
    end
  end

  // Per-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    if (m_seen) begin
      bit edv;
      edv = m_inflight && (m_age >= 1);
      chk("a_ready", 64'(bus.a_ready), 64'(!m_inflight || (FAST && edv && bus.d_ready)));
      chk("busy", 64'(busy), 64'(m_inflight));
      chk("d_valid", 64'(bus.d_valid), 64'(edv));
      if (edv) begin
        chk("d_opcode", 64'(bus.d_opcode), 64'(m_op));
        chk("d_size", 64'(bus.d_size), 64'(m_size));
        chk("d_source", 64'(bus.d_source), 64'(m_src));
        chk("d_denied", 64'(bus.d_denied), 64'(m_den));
        chk("d_data", bus.d_data, m_data);
      end else if (m_clean) begin
        chk("rst_d_opcode", 64'(bus.d_opcode), 64'd0);
        chk("rst_d_size", 64'(bus.d_size), 64'd0);
        chk("rst_d_source", 64'(bus.d_source), 64'd0);
        chk("rst_d_denied", 64'(bus.d_denied), 64'd0);
        chk("rst_d_data", bus.d_data, 64'd0);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  int          lat;
  logic [2:0]  r_op;
  logic [3:0]  r_src;
  logic        r_den;
  logic [63:0] r_data;

  task automatic send(input logic [2:0] op, input logic [2:0] size, input logic [63:0] addr,
                      input logic [7:0] mask, input logic [63:0] data, input logic [3:0] src);
    bit acc, ar;
    bus.a_opcode = op; bus.a_size = size; bus.a_address = addr;
    bus.a_mask = mask; bus.a_data = data; bus.a_source = src;
    bus.a_valid = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 30 && !acc; i++) begin
      @(negedge clk); ar = bus.a_ready;
      @(posedge clk); #1;
      if (ar) acc = 1'b1;
    end
    bus.a_valid = 1'b0;
    if (!acc) begin
      checks++; failures++;
      $display("FAIL accept_timeout: got no a_ready expected a_ready=1");
    end
  endtask

  task automatic wait_resp();
    bit got;
    got = 1'b0; lat = 0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk); lat++;
      if (bus.d_valid) got = 1'b1;
    end
    r_op = bus.d_opcode; r_src = bus.d_source; r_den = bus.d_denied; r_data = bus.d_data;
    if (!got) begin
      checks++; failures++;
      $display("FAIL resp_timeout: got no d_valid expected d_valid=1");
    end
  endtask

  // Full transaction with d_ready high: ends just after the D handshake edge.
  task automatic txn(input logic [2:0] op, input logic [2:0] size, input logic [63:0] addr,
                     input logic [7:0] mask, input logic [63:0] data, input logic [3:0] src);
    send(op, size, addr, mask, data, src);
    wait_resp();
    @(posedge clk); #1;
  endtask

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] hold_data;
    logic [2:0]  hold_op;
    logic [3:0]  hold_src;
    logic        hold_den;

    rst_n = 1'b0; bus.d_ready = 1'b1; bus.a_valid = 1'b0;
    bus.a_opcode = 3'd0; bus.a_size = 3'd0; bus.a_source = 4'd0;
    bus.a_address = 64'd0; bus.a_mask = 8'd0; bus.a_data = 64'd0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_a_ready", 64'(bus.a_ready), 64'd1);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_d_valid", 64'(bus.d_valid), 64'd0);
    @(posedge clk); #1;

    // Seed word 0 with a known pattern
    txn(3'd0, 3'd3, 64'h0000_0000_8000_0000, 8'hFF, 64'hDEAD_BEEF_0BAD_F00D, 4'd1);

    // Write then read
    txn(3'd0, 3'd3, 64'h0000_0000_8000_0010, 8'hFF, 64'h1122_3344_5566_7788, 4'd3);
    chk("put_opcode", 64'(r_op), 64'd0);
    chk("put_source", 64'(r_src), 64'd3);
    chk("put_denied", 64'(r_den), 64'd0);
    txn(3'd4, 3'd3, 64'h0000_0000_8000_0010, 8'hFF, 64'd0, 4'd5);
    chk("get_opcode", 64'(r_op), 64'd1);
    chk("get_data", r_data, 64'h1122_3344_5566_7788);
    chk("get_latency", 64'(lat), 64'd2);

    // Partial write
    txn(3'd1, 3'd3, 64'h0000_0000_8000_0010, 8'h0F, 64'hAAAA_AAAA_BBBB_BBBB, 4'd2);
    txn(3'd4, 3'd3, 64'h0000_0000_8000_0010, 8'hFF, 64'd0, 4'd2);
    chk("partial_data", r_data, 64'h1122_3344_BBBB_BBBB);

    // Out of range
    txn(3'd4, 3'd3, 64'h0000_0000_8000_8000, 8'hFF, 64'd0, 4'd4);
    chk("oor_get_denied", 64'(r_den), 64'd1);
    chk("oor_get_data", r_data, 64'd0);
    txn(3'd0, 3'd3, 64'h0000_0000_8000_8000, 8'hFF, 64'h5555_5555_5555_5555, 4'd4);
    chk("oor_put_denied", 64'(r_den), 64'd1);
    txn(3'd4, 3'd3, 64'h0000_0000_8000_0000, 8'hFF, 64'd0, 4'd6);
    chk("word0_unchanged", r_data, 64'hDEAD_BEEF_0BAD_F00D);

    // Below base, misaligned, oversize, illegal opcode
    txn(3'd4, 3'd3, 64'h0000_0000_7FFF_FFF8, 8'hFF, 64'd0, 4'd7);
    chk("below_base_denied", 64'(r_den), 64'd1);
    txn(3'd4, 3'd2, 64'h0000_0000_8000_0002, 8'h0F, 64'd0, 4'd8);
    chk("misaligned_denied", 64'(r_den), 64'd1);
    txn(3'd4, 3'd4, 64'h0000_0000_8000_0000, 8'hFF, 64'd0, 4'd9);
    chk("oversize_denied", 64'(r_den), 64'd1);
    txn(3'd6, 3'd3, 64'h0000_0000_8000_0000, 8'hFF, 64'd0, 4'd10);
    chk("illegal_op_denied", 64'(r_den), 64'd1);
    chk("illegal_op_opcode", 64'(r_op), 64'd0);

    // Last word boundary and aligned halfword access
    txn(3'd0, 3'd3, 64'h0000_0000_8000_7FF8, 8'hFF, 64'h0102_0304_0506_0708, 4'd11);
    chk("last_put_denied", 64'(r_den), 64'd0);
    txn(3'd4, 3'd1, 64'h0000_0000_8000_7FFA, 8'h0C, 64'd0, 4'd12);
    chk("last_get_data", r_data, 64'h0102_0304_0506_0708);

    // Backpressure: D fields stable for 5 cycles, then handshake
    bus.d_ready = 1'b0;
    send(3'd4, 3'd3, 64'h0000_0000_8000_0010, 8'hFF, 64'd0, 4'd13);
    wait_resp();
    hold_data = r_data; hold_op = r_op; hold_src = r_src; hold_den = r_den;
    chk("bp_data", hold_data, 64'h1122_3344_BBBB_BBBB);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_d_valid", 64'(bus.d_valid), 64'd1);
      chk("bp_d_data", bus.d_data, hold_data);
      chk("bp_d_opcode", 64'(bus.d_opcode), 64'(hold_op));
      chk("bp_d_source", 64'(bus.d_source), 64'(hold_src));
      chk("bp_d_denied", 64'(bus.d_denied), 64'(hold_den));
      chk("bp_a_ready", 64'(bus.a_ready), 64'd0);
      chk("bp_busy", 64'(busy), 64'd1);
    end
    @(posedge clk); #1 bus.d_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_release_busy", 64'(busy), 64'd0);
    chk("bp_release_d_valid", 64'(bus.d_valid), 64'd0);
    chk("bp_release_a_ready", 64'(bus.a_ready), 64'd1);
    @(posedge clk); #1;

    // Reset in the middle of RESP
    bus.d_ready = 1'b0;
    send(3'd4, 3'd3, 64'h0000_0000_8000_0000, 8'hFF, 64'd0, 4'd14);
    wait_resp();
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mid_d_valid", 64'(bus.d_valid), 64'd0);
    chk("rst_mid_a_ready", 64'(bus.a_ready), 64'd1);
    chk("rst_mid_busy", 64'(busy), 64'd0);
    bus.d_ready = 1'b1;
    @(posedge clk); #1;
    txn(3'd4, 3'd3, 64'h0000_0000_8000_0010, 8'hFF, 64'd0, 4'd15);
    chk("after_rst_data", r_data, 64'h1122_3344_BBBB_BBBB);

    // Four back-to-back Gets with a_valid and d_ready held high
    bus.a_opcode = 3'd4; bus.a_size = 3'd3; bus.a_address = 64'h0000_0000_8000_0000;
    bus.a_mask = 8'hFF; bus.a_data = 64'd0; bus.a_source = 4'd2;
    bus.a_valid = 1'b1;
    repeat (4) begin
      bit ar;
      ar = 1'b0;
      for (int i = 0; i < 10 && !ar; i++) begin
        @(negedge clk); ar = bus.a_ready;
        @(posedge clk); #1;
      end
      if (!ar) begin
        checks++; failures++;
        $display("FAIL b2b_accept: got no a_ready expected a_ready=1");
      end
    end
    bus.a_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
